// File: rtl/dmem_access_unit.sv
// Data-memory access sequencer between the MEM stage and the D-cache port: word/byte/indirect accesses.
// Optional performance counters are built only when DMEM_PERF_EN is defined.
module dmem_access_unit #(
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_read,
  input  logic              req_write,
  input  logic              req_indirect,
  input  logic              req_byte,
  input  logic [15:0]       req_addr,
  input  logic [15:0]       req_wdata,
  output logic [15:0]       req_rdata,
  output logic              done,
  output logic              stall,
  output logic [15:0]       dc_address,
  output logic              dc_read,
  output logic              dc_write,
  output logic [1:0]        dc_byte_enable,
  output logic [15:0]       dc_wdata,
  input  logic [15:0]       dc_rdata,
  input  logic              dc_resp,
  output logic [PERF_W-1:0] perf_accesses,
  output logic [PERF_W-1:0] perf_stall_cycles
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PTR  = 2'd1;
  localparam logic [1:0] ST_ACC  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] ea;
  logic [7:0]  lane;
  logic        req;

  assign req       = req_read | req_write;
  assign ea        = req_indirect ? ptr_q : req_addr;
  assign lane      = ea[0] ? dc_rdata[15:8] : dc_rdata[7:0];
  assign stall     = req && (state_q != ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign req_rdata = rdata_q;

  // Strobes decode from the registered state only, so they drop as soon as reset clears the state.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    rdata_d        = rdata_q;
    dc_read        = 1'b0;
    dc_write       = 1'b0;
    dc_address     = '0;
    dc_byte_enable = '0;
    dc_wdata       = '0;
    case (state_q)
      ST_IDLE: if (req) state_d = req_indirect ? ST_PTR : ST_ACC;
      ST_PTR: begin
        dc_read        = 1'b1;
        dc_address     = {req_addr[15:1], 1'b0};
        dc_byte_enable = 2'b11;
        if (dc_resp) begin
          ptr_d   = dc_rdata;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        // A dropped request still completes as a read so the cache handshake is not abandoned.
        dc_read  = !req_write;
        dc_write = req_write;
        if (req_byte) begin
          dc_address     = ea;
          dc_byte_enable = ea[0] ? 2'b10 : 2'b01;
          dc_wdata       = {req_wdata[7:0], req_wdata[7:0]};
        end else begin
          dc_address     = {ea[15:1], 1'b0};
          dc_byte_enable = 2'b11;
          dc_wdata       = req_wdata;
        end
        if (dc_resp) begin
          state_d = ST_DONE;
          if (!req_write) rdata_d = req_byte ? {{8{lane[7]}}, lane} : dc_rdata;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef DMEM_PERF_EN
  logic [PERF_W-1:0] perf_acc_q, perf_acc_d;
  logic [PERF_W-1:0] perf_stl_q, perf_stl_d;

  // Saturating counters: hold at all-ones instead of wrapping.
  always_comb begin
    perf_acc_d = perf_acc_q;
    perf_stl_d = perf_stl_q;
    if (done && !(&perf_acc_q))  perf_acc_d = perf_acc_q + {{(PERF_W-1){1'b0}}, 1'b1};
    if (stall && !(&perf_stl_q)) perf_stl_d = perf_stl_q + {{(PERF_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_acc_q <= '0;
      perf_stl_q <= '0;
    end else begin
      perf_acc_q <= perf_acc_d;
      perf_stl_q <= perf_stl_d;
    end
  end

  assign perf_accesses     = perf_acc_q;
  assign perf_stall_cycles = perf_stl_q;
`else
  assign perf_accesses     = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule
